imem_fetch_ctrl: RTL and testbench

Instruction-memory fetch controller directly upstream of the FETCH stage. It sequences single-outstanding requests to the instruction SRAM at the PC the FETCH stage presents. It generates the `FSM_SEL` (NOP/IMEM) select and the PC-advance enable that FETCH consumes. It also handles memory latency, IF/ID stalls, branch/trap redirects (`PC_Changed`) and misaligned PCs.

---
 rtl/my_pkg.sv | 24 ++
 rtl/fetch_wait_cnt.sv | 30 +++
 rtl/imem_fetch_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_imem_fetch_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/my_pkg.sv
// Shared types for the instruction-fetch front end.
//   FSM_Control_Enum   : FETCH stage instruction select (NOP bubble or SRAM data)
//   fetch_ctrl_state_e : imem_fetch_ctrl sequencer states
//   IMEM_LAT_MAX       : largest supported SRAM read latency in cycles
package my_pkg;

  typedef enum logic {
    NOP  = 1'b0,
    IMEM = 1'b1
  } FSM_Control_Enum;

  typedef enum logic [2:0] {
    IDLE,
    BOOT,
    ISSUE,
    WAIT,
    DELIVER,
    HALT
  } fetch_ctrl_state_e;

  localparam int IMEM_LAT_MAX    = 7;
  localparam int BOOT_CYCLES_MAX = 15;

endpackage

// File: rtl/fetch_wait_cnt.sv
// 4-bit loadable down-counter, shared by the boot-settle and memory-latency waits.
//   clk, rst_n : clock, async active-low reset
//   en         : decrement by one (saturates at zero)
//   load       : load load_val (wins over en)
//   load_val   : value to load
//   value      : current count
//   zero       : count is zero
module fetch_wait_cnt (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic [3:0] value,
  output logic       zero
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= 4'd0;
    end else if (load) begin
      value <= load_val;
    end else if (en && (value != 4'd0)) begin
      value <= value - 4'd1;
    end
  end

  assign zero = (value == 4'd0);

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction-memory fetch controller sitting in front of FETCH. Issues one
// outstanding SRAM read at a time at the PC FETCH presents, then tells FETCH
// whether to take the SRAM data or a NOP and when to advance its PC.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   IDLE    | out of reset, waiting for START
//   BOOT    | settle delay between START and the first request
//   ISSUE   | presenting a request at PC_add until the SRAM accepts it
//   WAIT    | request accepted, counting down the SRAM latency
//   DELIVER | SRAM data valid; hand it (or a NOP if killed) to FETCH
//   HALT    | misaligned PC seen; parked until START
//
// Ports:
//   CLK, RSTn    : clock, async active-low reset
//   EN           : global enable, 0 freezes everything and silences outputs
//   START        : leave IDLE/HALT and boot
//   PC_add       : PC from FETCH
//   PC_Changed   : FETCH is presenting a redirect target
//   STALL        : IF/ID cannot accept an instruction
//   IMEM_RDY     : SRAM accepts a request this cycle
//   IMEM_REQ     : request valid
//   IMEM_ADDR    : request byte address
//   FSM_SEL      : NOP / IMEM select to FETCH
//   FETCH_EN     : PC register load enable for FETCH
//   BUSY         : state is not IDLE/HALT
//   MISALIGN     : sticky misaligned-PC flag, cleared by START from HALT
module imem_fetch_ctrl
  import my_pkg::*;
#(
  parameter int IMEM_LAT    = 1,
  parameter int BOOT_CYCLES = 4
) (
  input  logic            CLK,
  input  logic            RSTn,
  input  logic            EN,
  input  logic            START,
  input  logic [31:0]     PC_add,
  input  logic            PC_Changed,
  input  logic            STALL,
  input  logic            IMEM_RDY,
  output logic            IMEM_REQ,
  output logic [31:0]     IMEM_ADDR,
  output FSM_Control_Enum FSM_SEL,
  output logic            FETCH_EN,
  output logic            BUSY,
  output logic            MISALIGN
);

  if (IMEM_LAT < 1 || IMEM_LAT > IMEM_LAT_MAX) begin : g_lat_range
    $error("imem_fetch_ctrl: IMEM_LAT out of range");
  end
  if (BOOT_CYCLES < 0 || BOOT_CYCLES > BOOT_CYCLES_MAX) begin : g_boot_range
    $error("imem_fetch_ctrl: BOOT_CYCLES out of range");
  end

  localparam logic [3:0] BOOT_LOAD = (BOOT_CYCLES > 0) ? 4'(BOOT_CYCLES - 1) : 4'd0;
  localparam logic [3:0] LAT_LOAD  = 4'(IMEM_LAT - 1);

  fetch_ctrl_state_e state_q, state_d;
  logic              kill_q, kill_d;
  logic              misalign_q, misalign_d;
  logic              cnt_en, cnt_load;
  logic [3:0]        cnt_load_val, cnt_value;
  logic              cnt_zero;

  fetch_wait_cnt u_wait_cnt (
    .clk      (CLK),
    .rst_n    (RSTn),
    .en       (cnt_en),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .value    (cnt_value),
    .zero     (cnt_zero)
  );

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q    <= IDLE;
      kill_q     <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      kill_q     <= kill_d;
      misalign_q <= misalign_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    kill_d       = kill_q;
    misalign_d   = misalign_q;
    cnt_en       = 1'b0;
    cnt_load     = 1'b0;
    cnt_load_val = 4'd0;
    IMEM_REQ     = 1'b0;
    IMEM_ADDR    = 32'd0;
    FSM_SEL      = NOP;
    FETCH_EN     = 1'b0;

    if (EN) begin
      unique case (state_q)
        IDLE, HALT: begin
          if (START) begin
            misalign_d = 1'b0;
            if (BOOT_CYCLES == 0) begin
              state_d = ISSUE;
            end else begin
              state_d      = BOOT;
              cnt_load     = 1'b1;
              cnt_load_val = BOOT_LOAD;
            end
          end
        end

        BOOT: begin
          if (cnt_zero) state_d = ISSUE;
          else          cnt_en  = 1'b1;
        end

        ISSUE: begin
          // A redirect replaces the PC, so alignment is only judged on a PC
          // that FETCH is not about to overwrite.
          if (PC_Changed) begin
            FETCH_EN = 1'b1;
          end else if (PC_add[1:0] != 2'b00) begin
            misalign_d = 1'b1;
            state_d    = HALT;
          end else begin
            IMEM_REQ  = 1'b1;
            IMEM_ADDR = PC_add;
            if (IMEM_RDY) begin
              if (IMEM_LAT == 1) begin
                state_d = DELIVER;
              end else begin
                state_d      = WAIT;
                cnt_load     = 1'b1;
                cnt_load_val = LAT_LOAD;
              end
            end
          end
        end

        WAIT: begin
          // The SRAM cannot cancel, so a redirect only marks the in-flight
          // response as dead; the wait runs to completion regardless.
          cnt_en = 1'b1;
          if (PC_Changed) begin
            FETCH_EN = 1'b1;
            kill_d   = 1'b1;
          end
          // Leave on the cycle the count steps to zero so the data shows up
          // exactly IMEM_LAT cycles after acceptance.
          if (cnt_value <= 4'd1) state_d = DELIVER;
        end

        DELIVER: begin
          if (PC_Changed) begin
            FETCH_EN = 1'b1;
            kill_d   = 1'b0;
            state_d  = ISSUE;
          end else if (kill_q) begin
            kill_d  = 1'b0;
            state_d = ISSUE;
          end else begin
            FSM_SEL = IMEM;
            if (!STALL) begin
              FETCH_EN = 1'b1;
              state_d  = ISSUE;
            end
          end
        end

        default: state_d = IDLE;
      endcase
    end
  end

  assign BUSY     = (state_q != IDLE) && (state_q != HALT);
  assign MISALIGN = misalign_q;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Bench for imem_fetch_ctrl with IMEM_LAT=3, BOOT_CYCLES=4. The stimulus plays
// the FETCH stage and SRAM handshake; every cycle in which the DUT accepts a
// request, asserts FETCH_EN, or selects IMEM is an event the monitor matches
// against the expected-event queue (tag = cycle count after the edge that
// starts that cycle).
module tb_imem_fetch_ctrl;
  import my_pkg::*;

  localparam int LAT  = 3;
  localparam int BOOT = 4;

  logic            CLK = 1'b0;
  logic            RSTn, EN, START, PC_Changed, STALL, IMEM_RDY;
  logic [31:0]     PC_add;
  logic            IMEM_REQ, FETCH_EN, BUSY, MISALIGN;
  logic [31:0]     IMEM_ADDR;
  FSM_Control_Enum FSM_SEL;

  typedef struct packed {
    int          tag;
    logic        acc;
    logic [31:0] addr;
    logic        fen;
    logic        sel;
  } ev_t;

  ev_t q[$];
  int  cyc = 0;
  int  total = 0;
  int  bad = 0;
  int  c, r;

  imem_fetch_ctrl #(.IMEM_LAT(LAT), .BOOT_CYCLES(BOOT)) dut (
    .CLK(CLK), .RSTn(RSTn), .EN(EN), .START(START), .PC_add(PC_add),
    .PC_Changed(PC_Changed), .STALL(STALL), .IMEM_RDY(IMEM_RDY),
    .IMEM_REQ(IMEM_REQ), .IMEM_ADDR(IMEM_ADDR), .FSM_SEL(FSM_SEL),
    .FETCH_EN(FETCH_EN), .BUSY(BUSY), .MISALIGN(MISALIGN)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic push(input int tag, input logic acc, input logic [31:0] addr,
                      input logic fen, input logic sel);
    q.push_back('{tag: tag, acc: acc, addr: addr, fen: fen, sel: sel});
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s @cyc %0d: got %h want %h", name, cyc, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic goto(input int t);
    while (cyc < t) step();
  endtask

  task automatic chk_reset_outputs(input string tagname);
    chk({tagname, "_req"},   {31'd0, IMEM_REQ}, 32'd0);
    chk({tagname, "_addr"},  IMEM_ADDR,         32'd0);
    chk({tagname, "_sel"},   {31'd0, FSM_SEL},  {31'd0, NOP});
    chk({tagname, "_fen"},   {31'd0, FETCH_EN}, 32'd0);
    chk({tagname, "_busy"},  {31'd0, BUSY},     32'd0);
    chk({tagname, "_mis"},   {31'd0, MISALIGN}, 32'd0);
  endtask

  // Monitor: every observable event is popped and compared.
  always @(negedge CLK) begin
    ev_t got, e;
    if (RSTn && ((IMEM_REQ && IMEM_RDY) || FETCH_EN || FSM_SEL == IMEM)) begin
      got.tag  = cyc;
      got.acc  = IMEM_REQ && IMEM_RDY;
      got.addr = got.acc ? IMEM_ADDR : 32'd0;
      got.fen  = FETCH_EN;
      got.sel  = FSM_SEL;
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_event: got tag=%0d acc=%0b addr=%h fen=%0b sel=%0b, want none",
                 got.tag, got.acc, got.addr, got.fen, got.sel);
      end else begin
        e = q.pop_front();
        if (e != got) begin
          bad++;
          $display("FAIL event: got tag=%0d acc=%0b addr=%h fen=%0b sel=%0b, want tag=%0d acc=%0b addr=%h fen=%0b sel=%0b",
                   got.tag, got.acc, got.addr, got.fen, got.sel,
                   e.tag, e.acc, e.addr, e.fen, e.sel);
        end
      end
    end
  end

  initial begin
    RSTn = 1'b1; EN = 1'b1; START = 1'b0; PC_add = 32'd0;
    PC_Changed = 1'b0; STALL = 1'b0; IMEM_RDY = 1'b1;
    #1 RSTn = 1'b0;
    #1 chk_reset_outputs("reset");
    repeat (3) step();
    RSTn = 1'b1;
    repeat (2) step();

    // Boot and first fetch: START sampled at edge c+1, BOOT c+1..c+4,
    // ISSUE c+5, WAIT c+6..c+7, DELIVER c+8.
    c = cyc;
    START = 1'b1; PC_add = 32'h0;
    push(c + 5, 1'b1, 32'h0, 1'b0, NOP);
    push(c + 8, 1'b0, 32'h0, 1'b1, IMEM);
    step();
    START = 1'b0;
    @(negedge CLK) chk("busy_boot", {31'd0, BUSY}, 32'd1);
    goto(c + 5);
    @(negedge CLK) chk("req_addr_first", IMEM_ADDR, 32'h0);

    // Ready backpressure at 0x40: request held for three cycles.
    goto(c + 9);
    PC_add = 32'h40; IMEM_RDY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) step();
      @(negedge CLK);
      chk("bp_req",  {31'd0, IMEM_REQ}, 32'd1);
      chk("bp_addr", IMEM_ADDR, 32'h40);
      chk("bp_fen",  {31'd0, FETCH_EN}, 32'd0);
    end
    goto(c + 12);
    IMEM_RDY = 1'b1;
    push(c + 12, 1'b1, 32'h40, 1'b0, NOP);

    // Stall for two cycles in DELIVER: IMEM held 3 cycles, one FETCH_EN.
    push(c + 15, 1'b0, 32'h0, 1'b0, IMEM);
    push(c + 16, 1'b0, 32'h0, 1'b0, IMEM);
    push(c + 17, 1'b0, 32'h0, 1'b1, IMEM);
    goto(c + 15);
    STALL = 1'b1;
    goto(c + 17);
    STALL = 1'b0;

    // Redirect during WAIT: killed response becomes a NOP, next fetch at 0x100.
    goto(c + 18);
    PC_add = 32'h44;
    push(c + 18, 1'b1, 32'h44, 1'b0, NOP);
    goto(c + 19);
    PC_Changed = 1'b1; PC_add = 32'h100;
    push(c + 19, 1'b0, 32'h0, 1'b1, NOP);
    goto(c + 20);
    PC_Changed = 1'b0;
    goto(c + 21);
    @(negedge CLK);
    chk("kill_sel",  {31'd0, FSM_SEL},  {31'd0, NOP});
    chk("kill_fen",  {31'd0, FETCH_EN}, 32'd0);
    chk("kill_busy", {31'd0, BUSY},     32'd1);
    push(c + 22, 1'b1, 32'h100, 1'b0, NOP);

    // Freeze for 5 cycles mid-WAIT: delivery moves from c+25 to c+30.
    push(c + 30, 1'b0, 32'h0, 1'b1, IMEM);
    goto(c + 24);
    EN = 1'b0;
    @(negedge CLK) chk("frz_busy", {31'd0, BUSY}, 32'd1);
    goto(c + 29);
    EN = 1'b1;

    // Misaligned PC: no request, HALT with MISALIGN, START recovers.
    goto(c + 31);
    PC_add = 32'h102;
    @(negedge CLK) chk("mis_req", {31'd0, IMEM_REQ}, 32'd0);
    goto(c + 32);
    @(negedge CLK);
    chk("mis_flag", {31'd0, MISALIGN}, 32'd1);
    chk("mis_busy", {31'd0, BUSY},     32'd0);
    goto(c + 34);
    START = 1'b1;
    step();
    START = 1'b0; PC_add = 32'h200;
    @(negedge CLK);
    chk("restart_mis",  {31'd0, MISALIGN}, 32'd0);
    chk("restart_busy", {31'd0, BUSY},     32'd1);
    push(c + 39, 1'b1, 32'h200, 1'b0, NOP);

    // Reset in the middle of WAIT: immediate, and IDLE ignores the SRAM.
    goto(c + 41);
    RSTn = 1'b0;
    #1 chk_reset_outputs("midrst");
    repeat (2) step();
    RSTn = 1'b1;
    repeat (8) step();
    @(negedge CLK);
    chk("idle_busy", {31'd0, BUSY},    32'd0);
    chk("idle_sel",  {31'd0, FSM_SEL}, {31'd0, NOP});

    // Redirect together with STALL in DELIVER: redirect wins.
    step();
    r = cyc;
    START = 1'b1; PC_add = 32'h300;
    push(r + 5,  1'b1, 32'h300, 1'b0, NOP);
    push(r + 8,  1'b0, 32'h0,   1'b1, NOP);
    push(r + 9,  1'b1, 32'h400, 1'b0, NOP);
    push(r + 12, 1'b0, 32'h0,   1'b1, IMEM);
    step();
    START = 1'b0;
    goto(r + 8);
    STALL = 1'b1; PC_Changed = 1'b1; PC_add = 32'h400;
    goto(r + 9);
    STALL = 1'b0; PC_Changed = 1'b0;
    goto(r + 13);
    IMEM_RDY = 1'b0; PC_add = 32'h404;
    goto(r + 16);
    @(negedge CLK);
    chk("events_left", q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
